// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    // Fetch sequencer states: issue request, wait for response, hold for decode.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Distance between consecutive instructions.
    localparam int unsigned PC_STEP = 4;

    // Default reset vector; instructions are word aligned.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Value forced into pc[1:0] so every fetch address is word aligned.
    localparam logic [1:0] ALIGN_LOW = 2'b00;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's redirect, instruction-memory and decode-side signals.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both 1. The imem request side may change its address while ready=0 (memory
// samples only on valid && ready). The decode side holds if_pc/if_instr stable
// while if_valid=1 and if_ready=0, except that a redirect withdraws if_valid.
// The response side has no ready: at most one request is outstanding and the
// word arrives in order with imem_rsp_valid.
interface fetch_unit_if #(
    parameter int WIDTH      = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [WIDTH-1:0]      redirect_pc;
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [WIDTH-1:0]      imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  if_valid;
    logic                  if_ready;
    logic [WIDTH-1:0]      if_pc;
    logic [DATA_WIDTH-1:0] if_instr;
    logic [WIDTH-1:0]      fetch_count;
    fetch_pkg::state_t     dbg_state;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        output fetch_count, dbg_state
    );

    // Environment side: execute, instruction memory and decode.
    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        input  fetch_count, dbg_state
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect > step > hold next-PC selection.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             step_en,
    output logic [WIDTH-1:0] pc
);
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    // Next PC: redirect wins over stepping; low bits always forced to word alignment.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (step_en) begin
            pc_d = pc_q + WIDTH'(PC_STEP);
        end
        pc_d[1:0] = ALIGN_LOW;
    end

    // PC state, asynchronously reset to the reset vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, a holding
// register toward decode, PC redirects and a delivered-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DATA_WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);
    state_t                state_d, state_q;
    logic                  kill_d, kill_q;
    logic                  req_valid_d, req_valid_q;
    logic [WIDTH-1:0]      if_pc_d, if_pc_q;
    logic [DATA_WIDTH-1:0] if_instr_d, if_instr_q;
    logic [WIDTH-1:0]      fetch_count_d, fetch_count_q;
    logic [WIDTH-1:0]      pc;
    logic                  if_valid_w;
    logic                  xfer;

    // A redirect in HOLD withdraws the held instruction in the same cycle.
    assign if_valid_w = (state_q == HOLD) && !bus.redirect_valid;
    assign xfer       = if_valid_w && bus.if_ready;

    fetch_pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .step_en        (xfer),
        .pc             (pc)
    );

    // Next-state logic for the sequencer, stale-response flag, holding registers and counter.
    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = WAIT;
                    // Redirect in the accept cycle: the coming response is for the old PC.
                    kill_d  = bus.redirect_valid;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (kill_q || bus.redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        if_instr_d = bus.imem_rsp_data;
                        if_pc_d    = pc;
                        state_d    = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    state_d = REQ;
                end else if (bus.if_ready) begin
                    state_d       = REQ;
                    fetch_count_d = fetch_count_q + 1'b1;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
        req_valid_d = (state_d == REQ);
    end

    // Sequencer and output registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= REQ;
            kill_q        <= 1'b0;
            req_valid_q   <= 1'b1;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            req_valid_q   <= req_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.if_valid       = if_valid_w;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.fetch_count    = fetch_count_q;
    assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (reset vector 0 and 0xFFFFFFFC),
// each with a one-cycle-latency instruction memory model and transfer logging.
module tb_fetch_unit;
    import fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    fetch_unit_if #(.WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    fetch_unit_if #(.WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    fetch_unit #(.WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fetch_unit #(.WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memory models / monitors ----------------
    logic        acc_a = 1'b0;
    logic        acc_b = 1'b0;
    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [31:0] req_q_a[$];
    logic [31:0] xfer_pc_a[$];
    logic [31:0] xfer_in_a[$];
    int          req_cyc_a[$];
    logic [31:0] req_q_b[$];
    logic [31:0] xfer_pc_b[$];
    logic [31:0] xfer_in_b[$];

    // Response one cycle after an accepted request; log accepts and decode transfers.
    always @(negedge clk) begin
        bus_a.imem_rsp_valid = acc_a;
        bus_a.imem_rsp_data  = acc_a ? word_a : 32'h0;
        acc_a = bus_a.imem_req_valid && bus_a.imem_req_ready;
        if (acc_a) begin
            req_q_a.push_back(bus_a.imem_req_addr);
            req_cyc_a.push_back(cyc_cnt);
        end
        if (bus_a.if_valid && bus_a.if_ready) begin
            xfer_pc_a.push_back(bus_a.if_pc);
            xfer_in_a.push_back(bus_a.if_instr);
        end
    end

    always @(negedge clk) begin
        bus_b.imem_rsp_valid = acc_b;
        bus_b.imem_rsp_data  = acc_b ? word_b : 32'h0;
        acc_b = bus_b.imem_req_valid && bus_b.imem_req_ready;
        if (acc_b) req_q_b.push_back(bus_b.imem_req_addr);
        if (bus_b.if_valid && bus_b.if_ready) begin
            xfer_pc_b.push_back(bus_b.if_pc);
            xfer_in_b.push_back(bus_b.if_instr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_req;
        int n_x;
        logic [31:0] cnt;

        rst = 1'b1;
        rst_b = 1'b1;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        bus_a.imem_req_ready = 1'b0;
        bus_a.if_ready       = 1'b0;
        bus_a.imem_rsp_valid = 1'b0;
        bus_a.imem_rsp_data  = '0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = '0;
        bus_b.imem_req_ready = 1'b0;
        bus_b.if_ready       = 1'b0;
        bus_b.imem_rsp_valid = 1'b0;
        bus_b.imem_rsp_data  = '0;
        word_a = 32'h0000_0013;
        word_b = 32'h0000_0013;
        cyc(2);

        // Reset state.
        check_eq("rst_state", 32'(bus_a.dbg_state), 32'(REQ));
        check_eq("rst_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check_eq("rst_req_addr", bus_a.imem_req_addr, 32'h0);
        check_eq("rst_if_valid", 32'(bus_a.if_valid), 32'd0);
        check_eq("rst_fetch_count", bus_a.fetch_count, 32'd0);
        check_eq("rst_if_pc", bus_a.if_pc, 32'h0);
        check_eq("rst_if_instr", bus_a.if_instr, 32'h0);

        // Streaming: 10 transfers, one every 3 cycles.
        rst = 1'b0;
        bus_a.imem_req_ready = 1'b1;
        bus_a.if_ready = 1'b1;
        check_eq("first_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        for (int i = 0; i < 100 && xfer_pc_a.size() < 10; i++) cyc(1);
        check_eq("stream_timeout", 32'(xfer_pc_a.size()), 32'd10);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 10 && i < xfer_pc_a.size(); i++) begin
            check_eq($sformatf("stream_if_pc%0d", i), xfer_pc_a[i], exp_q.pop_front());
        end
        check_eq("stream_instr", xfer_in_a[0], 32'h0000_0013);
        check_eq("stream_count", bus_a.fetch_count, 32'd10);
        check_eq("stream_req0", req_q_a[0], 32'h0);
        check_eq("stream_req1", req_q_a[1], 32'h4);
        check_eq("stream_req2", req_q_a[2], 32'h8);
        check_eq("stream_spacing", 32'(req_cyc_a[1] - req_cyc_a[0]), 32'd3);
        check_eq("stream_spacing2", 32'(req_cyc_a[2] - req_cyc_a[1]), 32'd3);

        // Decode backpressure for 5 cycles in HOLD.
        bus_a.if_ready = 1'b0;
        for (int i = 0; i < 20 && !bus_a.if_valid; i++) cyc(1);
        check_eq("stall_reach_hold", 32'(bus_a.if_valid), 32'd1);
        n_req = req_q_a.size();
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check_eq("stall_if_valid", 32'(bus_a.if_valid), 32'd1);
            check_eq("stall_if_pc", bus_a.if_pc, 32'h28);
            check_eq("stall_if_instr", bus_a.if_instr, 32'h0000_0013);
            check_eq("stall_req_valid", 32'(bus_a.imem_req_valid), 32'd0);
        end
        check_eq("stall_no_new_req", 32'(req_q_a.size()), 32'(n_req));
        check_eq("stall_count", bus_a.fetch_count, 32'd10);
        bus_a.if_ready = 1'b1;
        cyc(1);
        check_eq("release_count", bus_a.fetch_count, 32'd11);
        check_eq("release_addr", bus_a.imem_req_addr, 32'h2C);
        for (int i = 0; i < 20 && req_q_a.size() <= n_req; i++) cyc(1);
        check_eq("release_req_to", 32'(req_q_a.size()), 32'(n_req + 1));
        check_eq("release_req_addr", req_q_a[n_req], 32'h2C);

        // Redirect in the accept cycle: stale response dropped.
        bus_a.imem_req_ready = 1'b0;
        cyc(1);
        for (int i = 0; i < 20 && !bus_a.imem_req_valid; i++) cyc(1);
        check_eq("redir_reach_req", 32'(bus_a.imem_req_valid), 32'd1);
        n_req = req_q_a.size();
        n_x = xfer_pc_a.size();
        cnt = bus_a.fetch_count;
        bus_a.imem_req_ready = 1'b1;
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc = 32'h100;
        word_a = 32'hDEAD_BEEF;
        cyc(1);
        bus_a.redirect_valid = 1'b0;
        check_eq("redir_wait_state", 32'(bus_a.dbg_state), 32'(WAIT));
        check_eq("redir_wait_if_valid", 32'(bus_a.if_valid), 32'd0);
        cyc(1);
        check_eq("redir_drop_state", 32'(bus_a.dbg_state), 32'(REQ));
        check_eq("redir_drop_if_valid", 32'(bus_a.if_valid), 32'd0);
        check_eq("redir_drop_addr", bus_a.imem_req_addr, 32'h100);
        check_eq("redir_drop_count", bus_a.fetch_count, cnt);
        check_eq("redir_drop_no_xfer", 32'(xfer_pc_a.size()), 32'(n_x));
        for (int i = 0; i < 20 && xfer_pc_a.size() <= n_x; i++) cyc(1);
        check_eq("redir_xfer_to", 32'(xfer_pc_a.size()), 32'(n_x + 1));
        check_eq("redir_stale_req", req_q_a[n_req], 32'h30);
        check_eq("redir_new_req", req_q_a[n_req + 1], 32'h100);
        check_eq("redir_first_pc", xfer_pc_a[n_x], 32'h100);
        check_eq("redir_first_instr", xfer_in_a[n_x], 32'hDEAD_BEEF);

        // Redirect with unaligned target while holding for decode.
        bus_a.if_ready = 1'b0;
        for (int i = 0; i < 20 && !bus_a.if_valid; i++) cyc(1);
        check_eq("hold_redir_reach", 32'(bus_a.if_valid), 32'd1);
        cnt = bus_a.fetch_count;
        n_x = xfer_pc_a.size();
        n_req = req_q_a.size();
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc = 32'h203;
        bus_a.if_ready = 1'b1;
        #1;
        check_eq("hold_redir_mask", 32'(bus_a.if_valid), 32'd0);
        cyc(1);
        bus_a.redirect_valid = 1'b0;
        check_eq("hold_redir_count", bus_a.fetch_count, cnt);
        check_eq("hold_redir_no_xfer", 32'(xfer_pc_a.size()), 32'(n_x));
        check_eq("hold_redir_state", 32'(bus_a.dbg_state), 32'(REQ));
        check_eq("hold_redir_addr", bus_a.imem_req_addr, 32'h200);
        for (int i = 0; i < 20 && req_q_a.size() <= n_req; i++) cyc(1);
        check_eq("hold_redir_req_to", 32'(req_q_a.size()), 32'(n_req + 1));
        check_eq("hold_redir_req", req_q_a[n_req], 32'h200);

        // Asynchronous reset in WAIT with a response in flight.
        bus_a.imem_req_ready = 1'b0;
        cyc(1);
        for (int i = 0; i < 20 && !bus_a.imem_req_valid; i++) cyc(1);
        check_eq("rstw_reach_req", 32'(bus_a.imem_req_valid), 32'd1);
        bus_a.imem_req_ready = 1'b1;
        word_a = 32'hBAD0_0BAD;
        cyc(1);
        check_eq("rstw_in_wait", 32'(bus_a.dbg_state), 32'(WAIT));
        rst = 1'b1;
        bus_a.imem_req_ready = 1'b0;
        #1;
        check_eq("rstw_async_state", 32'(bus_a.dbg_state), 32'(REQ));
        check_eq("rstw_async_count", bus_a.fetch_count, 32'd0);
        check_eq("rstw_async_if_pc", bus_a.if_pc, 32'h0);
        check_eq("rstw_async_req_valid", 32'(bus_a.imem_req_valid), 32'd1);
        check_eq("rstw_async_addr", bus_a.imem_req_addr, 32'h0);
        #1;
        rst = 1'b0;
        n_x = xfer_pc_a.size();
        n_req = req_q_a.size();
        cyc(1);
        word_a = 32'h1234_5678;
        check_eq("rstw_stale_state", 32'(bus_a.dbg_state), 32'(REQ));
        check_eq("rstw_stale_if_valid", 32'(bus_a.if_valid), 32'd0);
        bus_a.imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && xfer_pc_a.size() <= n_x; i++) cyc(1);
        check_eq("rstw_xfer_to", 32'(xfer_pc_a.size()), 32'(n_x + 1));
        check_eq("rstw_first_req", req_q_a[n_req], 32'h0);
        check_eq("rstw_first_pc", xfer_pc_a[n_x], 32'h0);
        check_eq("rstw_first_instr", xfer_in_a[n_x], 32'h1234_5678);

        // PC and fetch_count wrap on the second instance.
        rst_b = 1'b0;
        bus_b.imem_req_ready = 1'b1;
        bus_b.if_ready = 1'b1;
        check_eq("wrap_rst_addr", bus_b.imem_req_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && xfer_pc_b.size() < 1; i++) cyc(1);
        check_eq("wrap_xfer_to", 32'(xfer_pc_b.size()), 32'd1);
        check_eq("wrap_first_pc", xfer_pc_b[0], 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && req_q_b.size() < 2; i++) cyc(1);
        check_eq("wrap_req_to", 32'(req_q_b.size()), 32'd2);
        check_eq("wrap_req1", req_q_b[1], 32'h0);
        bus_b.if_ready = 1'b0;
        for (int i = 0; i < 20 && !bus_b.if_valid; i++) cyc(1);
        check_eq("wrap_hold_reach", 32'(bus_b.if_valid), 32'd1);
        check_eq("wrap_hold_pc", bus_b.if_pc, 32'h0);
        check_eq("wrap_count1", bus_b.fetch_count, 32'd1);
        force dut_b.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut_b.fetch_count_q;
        #1;
        check_eq("wrap_count_preload", bus_b.fetch_count, 32'hFFFF_FFFF);
        bus_b.if_ready = 1'b1;
        cyc(1);
        check_eq("wrap_count_zero", bus_b.fetch_count, 32'd0);
        check_eq("wrap_next_addr", bus_b.imem_req_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit in case a stall escapes the bounded loops.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the core: owns the program counter and steps it by 4 per instruction delivered.
- Issues one request at a time to instruction memory and holds the returned word for decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from execute.
- Keeps a free-running count of instructions delivered to decode.

Parameters:
- WIDTH, 32, PC/address width and fetch_count width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  replace PC with redirect_pc this cycle.
- redirect_pc  in  WIDTH  redirect target; bits [1:0] ignored (treated as 00).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  WIDTH  fetch address (= pc).
- imem_rsp_valid  in  1  response word valid; in order, at most one outstanding.
- imem_rsp_data  in  DATA_WIDTH  response instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction.
- if_pc  out  WIDTH  PC of the presented instruction.
- if_instr  out  DATA_WIDTH  presented instruction.
- fetch_count  out  WIDTH  number of completed if transfers, wraps modulo 2^WIDTH.

Behaviour:
- Reset (async, active-high):
  - Outputs: pc=RESET_PC, state=REQ, kill=0, fetch_count=0, if_pc=0, if_instr=0, if_valid=0.
  - imem_req_valid is 1 on the first cycle after rst deasserts.
  - Reset mid-transaction abandons any outstanding request; a response arriving after reset is ignored because state is REQ.
- States: REQ, WAIT, HOLD. Flag kill marks the outstanding response as stale.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc. The address may change while ready=0; memory samples only on valid&&ready.
  - Accept with no redirect -> WAIT.
  - Redirect without accept -> pc=redirect_pc, stay REQ.
  - Redirect together with accept -> pc=redirect_pc, kill=1, -> WAIT.
- WAIT:
  - imem_req_valid=0.
  - rsp_valid with kill=0 and no redirect -> if_instr=rsp_data, if_pc=pc, -> HOLD.
  - rsp_valid with kill=1 or redirect -> response dropped, kill=0, -> REQ; on redirect, pc=redirect_pc.
  - Redirect without rsp -> pc=redirect_pc, kill=1, stay WAIT.
- HOLD:
  - if_valid = (state==HOLD) & ~redirect_valid (combinational mask).
  - if_valid&&if_ready -> pc=pc+4, fetch_count+1, -> REQ.
  - Redirect -> output dropped (no transfer, no count), pc=redirect_pc, -> REQ.
  - if_pc and if_instr are stable while if_valid=1 and if_ready=0.
- Latency:
  - With ready and response both immediate, one instruction per 3 cycles: REQ -> WAIT -> HOLD.
  - If rsp_valid arrives in the cycle after the accept, if_valid rises 2 cycles after the accept.
- Arithmetic:
  - pc+4 wraps modulo 2^WIDTH: 32'hFFFF_FFFC -> 0.
  - fetch_count wraps 32'hFFFF_FFFF -> 0.
- Invariants:
  - At most one outstanding request.
  - imem_req_valid is never 1 outside REQ.
  - rsp_valid in REQ or HOLD is a protocol error and is ignored.

Decomposition:
- Package fetch_pkg:
  - state enum (REQ, WAIT, HOLD).
  - PC_STEP=4.
  - Default RESET_PC and alignment mask.
- Sub-module fetch_pc_reg:
  - PC register with async reset to RESET_PC.
  - Next-PC mux with priority redirect > step > hold, forcing bits [1:0]=0.
- The FSM, kill flag, output holding registers and fetch_count stay in fetch_unit.

Test Plan:
- Reset, then imem returns 0x00000013 with ready=1 and a 1-cycle response, if_ready=1 -> requests at 0x0, 0x4, 0x8, one per 3 cycles; after 10 transfers fetch_count=10 and last if_pc=0x24.
- if_ready=0 for 5 cycles in HOLD -> if_valid stays 1, if_pc/if_instr stable, no new request; on release, next request addr = old pc+4, fetch_count increments once.
- redirect_valid with redirect_pc=0x100 in the cycle the request is accepted -> the following response is dropped (if_valid stays 0), next request addr=0x100, first delivered if_pc=0x100.
- redirect_pc=0x203 asserted while in HOLD with if_ready=1 -> no transfer, fetch_count unchanged, next request addr=0x200.
- RESET_PC=0xFFFFFFFC -> first if_pc=0xFFFFFFFC, next request addr=0x0; fetch_count preloaded to 0xFFFFFFFF by force -> 0 after the next transfer.
- rst asserted in WAIT with a response pending -> outputs reset immediately (async); a stale response arriving after release is ignored; first request addr=RESET_PC.
